// File: rtl/vram_write_scheduler_pkg.sv
// Shared frame-size defaults, state codes and colour constants for the VRAM write scheduler.
// Also holds the helper that marks states where the frame contents are valid.
package vram_write_scheduler_pkg;

  localparam int WIDTH_SIZE_RAM  = 640;
  localparam int HEIGHT_SIZE_RAM = 480;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FILL  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_PIX   = 2'd3
  } state_t;

  function automatic logic frame_valid(input state_t s);
    return (s == ST_IDLE) || (s == ST_PIX);
  endfunction

endpackage

// File: rtl/vram_addr_calc.sv
// Linear VRAM address from pixel coordinates, plus a flag for coordinates inside the frame.
module vram_addr_calc #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 25
) (
  input  logic [10:0]       col,
  input  logic [9:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign addr     = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
  assign in_range = (32'(col) < WIDTH) && (32'(row) < HEIGHT);

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between a full-frame fill engine and a pixel writer.
// Outputs are registered from the next-state decode, so they line up with the state they describe.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int               DATA_W     = 3,
  parameter int               WIDTH      = WIDTH_SIZE_RAM,
  parameter int               HEIGHT     = HEIGHT_SIZE_RAM,
  parameter int               ADDR_W     = 25,
  parameter logic [DATA_W-1:0] INIT_COLOR = DATA_W'(COLOR_BLACK)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              iFillReq,
  input  logic [DATA_W-1:0] iFillColor,
  input  logic              iPixReq,
  input  logic [10:0]       iPixCol,
  input  logic [9:0]        iPixRow,
  input  logic [DATA_W-1:0] iPixRGB,
  output logic              oPixAck,
  output logic              oPixDropped,
  output logic              oWriteEnable,
  output logic [ADDR_W-1:0] oWriteAddress,
  output logic [DATA_W-1:0] oWriteData,
  output logic              oReady,
  output logic              oBusy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   counter_reg, counter_next;
  logic [DATA_W-1:0]   fill_color_reg, fill_color_next;
  logic                we_next, ack_next, drop_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   pix_addr;
  logic                pix_in_range;

  vram_addr_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .col      (iPixCol),
    .row      (iPixRow),
    .addr     (pix_addr),
    .in_range (pix_in_range)
  );

  always_comb begin
    state_next      = state_reg;
    counter_next    = counter_reg;
    fill_color_next = fill_color_reg;
    we_next         = 1'b0;
    addr_next       = '0;
    data_next       = '0;
    ack_next        = 1'b0;
    drop_next       = 1'b0;

    unique case (state_reg)
      ST_RESET: begin
        state_next   = ST_FILL;
        counter_next = '0;
      end
      ST_FILL: begin
        if (counter_reg == LAST_ADDR) begin
          state_next   = ST_IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        // Fill wins over a simultaneous pixel request; the pixel stays pending.
        if (iFillReq) begin
          fill_color_next = iFillColor;
          counter_next    = '0;
          state_next      = ST_FILL;
        end else if (iPixReq) begin
          state_next = ST_PIX;
          ack_next   = 1'b1;
          drop_next  = !pix_in_range;
          if (pix_in_range) begin
            we_next   = 1'b1;
            addr_next = pix_addr;
            data_next = iPixRGB;
          end
        end
      end
      ST_PIX: state_next = ST_IDLE;
      default: state_next = ST_RESET;
    endcase

    if (state_next == ST_FILL) begin
      we_next   = 1'b1;
      addr_next = counter_next;
      data_next = fill_color_next;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg      <= ST_RESET;
      counter_reg    <= '0;
      fill_color_reg <= INIT_COLOR;
      oWriteEnable   <= 1'b0;
      oWriteAddress  <= '0;
      oWriteData     <= '0;
      oPixAck        <= 1'b0;
      oPixDropped    <= 1'b0;
      oReady         <= 1'b0;
      oBusy          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      fill_color_reg <= fill_color_next;
      oWriteEnable   <= we_next;
      oWriteAddress  <= addr_next;
      oWriteData     <= data_next;
      oPixAck        <= ack_next;
      oPixDropped    <= drop_next;
      oReady         <= frame_valid(state_next);
      oBusy          <= !frame_valid(state_next);
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler on an 8x4 frame: expected writes/acks are queued
// as stimulus is driven and compared in order whenever the DUT writes or acknowledges.
module tb_vram_write_scheduler;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 25;
  localparam int DW    = 3;
  localparam int FRAME = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fill_req = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic          pix_req = 1'b0;
  logic [10:0]   pix_col = '0;
  logic [9:0]    pix_row = '0;
  logic [DW-1:0] pix_rgb = '0;
  logic          pix_ack, pix_dropped, write_enable, ready, busy;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;

  always #5 clk = ~clk;

  vram_write_scheduler #(
    .DATA_W     (DW),
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .INIT_COLOR (3'b000)
  ) dut (
    .CLK           (clk),
    .Reset         (rst),
    .iFillReq      (fill_req),
    .iFillColor    (fill_color),
    .iPixReq       (pix_req),
    .iPixCol       (pix_col),
    .iPixRow       (pix_row),
    .iPixRGB       (pix_rgb),
    .oPixAck       (pix_ack),
    .oPixDropped   (pix_dropped),
    .oWriteEnable  (write_enable),
    .oWriteAddress (write_address),
    .oWriteData    (write_data),
    .oReady        (ready),
    .oBusy         (busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ack;
    logic          drop;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic ack, input logic drop);
    ev_t e;
    e.we = we; e.addr = addr; e.data = data; e.ack = ack; e.drop = drop;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input logic [DW-1:0] c, input int count);
    for (int i = 0; i < count; i++) push_ev(1'b1, AW'(i), c, 1'b0, 1'b0);
  endtask

  // Monitor: every write or ack must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (write_enable || pix_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {62'd0, write_enable, pix_ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.we ? "write_event" : "drop_event",
              {33'd0, write_enable, (e.we ? write_address : {AW{1'b0}}),
               (e.we ? write_data : {DW{1'b0}}), pix_ack, pix_dropped},
              {33'd0, e.we, (e.we ? e.addr : {AW{1'b0}}),
               (e.we ? e.data : {DW{1'b0}}), e.ack, e.drop});
        $display("event we=%0d addr=%0d data=%0d ack=%0d drop=%0d",
                 write_enable, write_address, write_data, pix_ack, pix_dropped);
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 200);
    check("ready_within_bound", {63'd0, ready}, 64'd1);
  endtask

  // Called at a negedge while idle; returns at a negedge back in idle.
  task automatic do_pix(input int col, input int row, input logic [DW-1:0] rgb);
    int n = 0;
    if (col < W && row < H) push_ev(1'b1, AW'(row * W + col), rgb, 1'b1, 1'b0);
    else                    push_ev(1'b0, '0, '0, 1'b1, 1'b1);
    pix_col = 11'(col);
    pix_row = 10'(row);
    pix_rgb = rgb;
    pix_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ack && n < 10);
    check("pix_ack_latency", 64'(n), 64'd1);
    pix_req = 1'b0;
    @(negedge clk);
    check("pix_we_after", {63'd0, write_enable}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] ack_bits;

    repeat (3) @(negedge clk);
    check("reset_outputs", {31'd0, write_enable, write_address, write_data,
                            pix_ack, pix_dropped, ready, busy}, 64'd0);

    // Post-reset fill of INIT_COLOR, ready the cycle after the last address
    push_fill(3'b000, FRAME);
    rst = 1'b0;
    wait_ready(n);
    check("post_reset_fill_cycles", 64'(n), 64'(FRAME + 1));
    check("busy_after_fill", {63'd0, busy}, 64'd0);

    do_pix(3, 2, 3'b101);

    // Held request: accepted every other cycle
    for (int i = 0; i < 3; i++) push_ev(1'b1, '0, 3'b011, 1'b1, 1'b0);
    pix_col = '0; pix_row = '0; pix_rgb = 3'b011; pix_req = 1'b1;
    ack_bits = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ack_bits[i] = pix_ack;
    end
    pix_req = 1'b0;
    check("held_req_acks", {58'd0, ack_bits}, 64'b010101);

    do_pix(8, 0, 3'b001);
    do_pix(0, 4, 3'b010);
    do_pix(7, 3, 3'b110);
    do_pix(2047, 1023, 3'b111);
    do_pix(7, 0, 3'b001);

    // Fill and pixel together: fill first, pixel afterwards
    push_fill(3'b010, FRAME);
    push_ev(1'b1, AW'(1 * W + 1), 3'b111, 1'b1, 1'b0);
    fill_color = 3'b010; fill_req = 1'b1;
    pix_col = 11'd1; pix_row = 10'd1; pix_rgb = 3'b111; pix_req = 1'b1;
    @(negedge clk);
    check("fill_accept_busy", {62'd0, busy, ready}, 64'b10);
    fill_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ack && n < 100);
    check("pix_after_fill_cycles", 64'(n), 64'(FRAME + 1));
    pix_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a fill
    push_fill(3'b110, 14);
    fill_color = 3'b110; fill_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      fill_req = 1'b0;
      n++;
    end while (!(write_enable && write_address == AW'(13)) && n < 100);
    check("fill_reached_13", 64'(write_address), 64'd13);
    check("busy_mid_fill", {62'd0, busy, ready}, 64'b10);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {31'd0, write_enable, write_address, write_data,
                                     pix_ack, pix_dropped, ready, busy}, 64'd0);
    push_fill(3'b000, FRAME);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("refill_cycles", 64'(n), 64'(FRAME + 1));

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
